// File: rtl/id_token_scanner_if.sv
// Character-stream / token-report bundle between a character source and id_token_scanner.
// The master drives characters; the slave (the scanner) returns the registered token report.
interface id_token_scanner_if #(
   parameter int CHAR_W  = 8,
   parameter int MAX_LEN = 31
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic [CHAR_W-1:0] char_data;
   logic              char_valid;
   logic              id_match;
   logic              tok_done;
   logic [1:0]        tok_type;
   logic [LEN_W-1:0]  tok_len;
   logic              tok_ovf;

   modport master (
      output char_data, char_valid,
      input  id_match, tok_done, tok_type, tok_len, tok_ovf
   );

   modport slave (
      input  char_data, char_valid,
      output id_match, tok_done, tok_type, tok_len, tok_ovf
   );
endinterface

// File: rtl/id_token_scanner.sv
// Streaming classifier that splits characters into IDENT / NUMBER / BAD tokens with saturating lengths.
// Optional macro ID_TOKEN_UNDERSCORE_EN makes '_' a letter instead of a delimiter.
module id_token_scanner #(
   parameter int CHAR_W  = 8,
   parameter int MAX_LEN = 31
) (
   input logic                clk,
   input logic                rst_n,
   id_token_scanner_if.slave  scan_io
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   localparam logic [1:0] TYPE_IDENT  = 2'b01;
   localparam logic [1:0] TYPE_NUMBER = 2'b10;
   localparam logic [1:0] TYPE_BAD    = 2'b11;

   typedef enum logic [1:0] {IDLE, IDENT, NUM, BAD} state_t;
   typedef enum logic [1:0] {CLS_L, CLS_D, CLS_X} class_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             id_match_q, id_match_d;
   logic             tok_done_q, tok_done_d;
   logic [1:0]       tok_type_q, tok_type_d;
   logic [LEN_W-1:0] tok_len_q, tok_len_d;
   logic             tok_ovf_q, tok_ovf_d;

   class_t     cls;
   logic [7:0] chrLow;
   logic       upperZero;
   logic       doGrow;
   logic       doEmit;
   logic [1:0] emitType;

   // Any set bit above the byte forces a delimiter regardless of the low byte.
   always_comb begin
      chrLow    = scan_io.char_data[7:0];
      upperZero = ((scan_io.char_data >> 8) == '0);
      cls       = CLS_X;
      if (upperZero) begin
         if ((chrLow >= 8'd97 && chrLow <= 8'd122) || (chrLow >= 8'd65 && chrLow <= 8'd90))
            cls = CLS_L;
         else if (chrLow >= 8'd48 && chrLow <= 8'd57)
            cls = CLS_D;
`ifdef ID_TOKEN_UNDERSCORE_EN
         else if (chrLow == 8'd95)
            cls = CLS_L;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      id_match_d = id_match_q;
      tok_done_d = 1'b0;
      tok_type_d = tok_type_q;
      tok_len_d  = tok_len_q;
      tok_ovf_d  = tok_ovf_q;
      doGrow     = 1'b0;
      doEmit     = 1'b0;
      emitType   = TYPE_IDENT;

      if (scan_io.char_valid) begin
         id_match_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cls == CLS_L) begin
                  state_d = IDENT;
                  cnt_d   = LEN_W'(1);
               end else if (cls == CLS_D) begin
                  state_d = NUM;
                  cnt_d   = LEN_W'(1);
               end
            end
            IDENT: begin
               if (cls == CLS_X) begin
                  doEmit   = 1'b1;
                  emitType = TYPE_IDENT;
               end else begin
                  doGrow     = 1'b1;
                  id_match_d = (cls == CLS_D);
               end
            end
            NUM: begin
               if (cls == CLS_X) begin
                  doEmit   = 1'b1;
                  emitType = TYPE_NUMBER;
               end else begin
                  doGrow = 1'b1;
                  if (cls == CLS_L) state_d = BAD;
               end
            end
            BAD: begin
               if (cls == CLS_X) begin
                  doEmit   = 1'b1;
                  emitType = TYPE_BAD;
               end else begin
                  doGrow = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         // Saturate at MAX_LEN; the sticky ovf remembers that characters were dropped from the count.
         if (doGrow) begin
            if (cnt_q == LEN_W'(MAX_LEN)) ovf_d = 1'b1;
            else                          cnt_d = cnt_q + LEN_W'(1);
         end

         if (doEmit) begin
            state_d    = IDLE;
            tok_done_d = 1'b1;
            tok_type_d = emitType;
            tok_len_d  = cnt_q;
            tok_ovf_d  = ovf_q;
            cnt_d      = '0;
            ovf_d      = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         id_match_q <= 1'b0;
         tok_done_q <= 1'b0;
         tok_type_q <= 2'b00;
         tok_len_q  <= '0;
         tok_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         id_match_q <= id_match_d;
         tok_done_q <= tok_done_d;
         tok_type_q <= tok_type_d;
         tok_len_q  <= tok_len_d;
         tok_ovf_q  <= tok_ovf_d;
      end
   end

   assign scan_io.id_match = id_match_q;
   assign scan_io.tok_done = tok_done_q;
   assign scan_io.tok_type = tok_type_q;
   assign scan_io.tok_len  = tok_len_q;
   assign scan_io.tok_ovf  = tok_ovf_q;
endmodule

// File: tb/tb_id_token_scanner.sv
// Scoreboard bench for id_token_scanner: a token-buffer reference model queues the expected
// report for every consumed character and a negedge monitor compares it against the DUT.
module tb_id_token_scanner;
   localparam int CHAR_W  = 9;
   localparam int MAX_LEN = 3;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   typedef struct {
      bit idm;
      bit done;
      int typ;
      int len;
      bit ovf;
   } expRec_t;

   logic clk = 1'b0;
   logic rst_n;

   id_token_scanner_if #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN)) bus ();

   id_token_scanner #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scan_io (bus.slave)
   );

   always #5 clk = ~clk;

   expRec_t expQ[$];
   int      tokBuf[$];
   int      lastType = 0;
   int      lastLen  = 0;
   bit      lastOvf  = 1'b0;
   int      compared = 0;
   int      mismatched = 0;
   bit      consumedFlag = 1'b0;
   bit      monitorOn = 1'b0;

   // Classes: 0 letter, 1 digit, 2 delimiter.
   function automatic int classOf(input logic [CHAR_W-1:0] c);
      if (c[CHAR_W-1:8] != '0) return 2;
      if ((c[7:0] >= 8'd97 && c[7:0] <= 8'd122) || (c[7:0] >= 8'd65 && c[7:0] <= 8'd90)) return 0;
      if (c[7:0] >= 8'd48 && c[7:0] <= 8'd57) return 1;
`ifdef ID_TOKEN_UNDERSCORE_EN
      if (c[7:0] == 8'd95) return 0;
`endif
      return 2;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of input and, when valid, queues what the DUT must report one edge later.
   task automatic applyStimulus(input logic [CHAR_W-1:0] c, input bit v);
      expRec_t e;
      int      cls;
      bit      allDigits;
      @(posedge clk);
      #2;
      bus.char_data  = c;
      bus.char_valid = v;
      if (v) begin
         cls    = classOf(c);
         e.done = 1'b0;
         if (cls != 2) begin
            tokBuf.push_back(cls);
         end else if (tokBuf.size() > 0) begin
            allDigits = 1'b1;
            foreach (tokBuf[i]) if (tokBuf[i] != 1) allDigits = 1'b0;
            if (tokBuf[0] == 0)  lastType = 1;
            else if (allDigits)  lastType = 2;
            else                 lastType = 3;
            lastLen = (tokBuf.size() > MAX_LEN) ? MAX_LEN : tokBuf.size();
            lastOvf = (tokBuf.size() > MAX_LEN);
            e.done  = 1'b1;
            tokBuf.delete();
         end
         e.idm = (tokBuf.size() > 0) && (tokBuf[0] == 0) && (tokBuf[tokBuf.size()-1] == 1);
         e.typ = lastType;
         e.len = lastLen;
         e.ovf = lastOvf;
         expQ.push_back(e);
      end
   endtask

   task automatic sendString(input string s);
      for (int i = 0; i < s.len(); i++) applyStimulus(CHAR_W'(s[i]), 1'b1);
   endtask

   task automatic doReset(input int cycles);
      @(posedge clk);
      #2;
      rst_n          = 1'b0;
      bus.char_valid = 1'b0;
      tokBuf.delete();
      lastType = 0;
      lastLen  = 0;
      lastOvf  = 1'b0;
      repeat (cycles) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   always @(posedge clk) consumedFlag <= bus.char_valid && rst_n;

   always @(negedge clk) begin
      expRec_t e;
      if (monitorOn) begin
         if (consumedFlag) begin
            if (expQ.size() == 0) begin
               checkOutput("scoreboard_underflow", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("id_match", int'(bus.id_match), int'(e.idm));
               checkOutput("tok_done", int'(bus.tok_done), int'(e.done));
               checkOutput("tok_type", int'(bus.tok_type), e.typ);
               checkOutput("tok_len",  int'(bus.tok_len),  e.len);
               checkOutput("tok_ovf",  int'(bus.tok_ovf),  int'(e.ovf));
            end
         end else begin
            checkOutput("tok_done_stalled", int'(bus.tok_done), 0);
         end
      end
   end

   initial begin
      int r;
      logic [CHAR_W-1:0] c;
      byte delims[4];
      delims = '{8'd32, 8'd44, 8'd59, 8'd95};

      rst_n          = 1'b0;
      bus.char_data  = '0;
      bus.char_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_id_match", int'(bus.id_match), 0);
      checkOutput("reset_tok_done", int'(bus.tok_done), 0);
      checkOutput("reset_tok_type", int'(bus.tok_type), 0);
      checkOutput("reset_tok_len",  int'(bus.tok_len),  0);
      checkOutput("reset_tok_ovf",  int'(bus.tok_ovf),  0);
      monitorOn = 1'b1;

      sendString("ab1;");
      sendString("42 ");
      sendString("9x7 ");
      sendString("abcde;");
      sendString("q;");
      sendString("a,b,");
      sendString("a");
      for (int i = 0; i < 5; i++) applyStimulus(CHAR_W'($urandom), 1'b0);
      sendString("1;");
      sendString("ab");
      doReset(1);
      sendString(";x_;");
      applyStimulus(9'h161, 1'b1);
      applyStimulus(9'h062, 1'b1);
      applyStimulus(9'h141, 1'b1);
      sendString(";");

      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: c = CHAR_W'(8'd97 + 8'($urandom_range(0, 25)));
            4:          c = CHAR_W'(8'd65 + 8'($urandom_range(0, 25)));
            5, 6, 7:    c = CHAR_W'(8'd48 + 8'($urandom_range(0, 9)));
            8:          c = CHAR_W'(delims[$urandom_range(0, 3)]);
            default:    c = {1'b1, 8'd97 + 8'($urandom_range(0, 25))};
         endcase
         applyStimulus(c, ($urandom_range(0, 99) < 85));
      end
      sendString(";");
      for (int i = 0; i < 4; i++) applyStimulus('0, 1'b0);

      checkOutput("scoreboard_drain", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
